// File: rtl/popcount23_pattern_gen.sv
// popcount23_pattern_gen
//   Enumerates every WIDTH-bit word whose popcount equals k, one per
//   valid/ready handshake, in ascending numeric order. Successors come
//   from Gosper's hack, evaluated on WIDTH+1 bits in one cycle.
//
// Ports
//   clk_i        clock, rising edge
//   rst_n_i      asynchronous active-low reset
//   start_i      begin enumeration for k_i (sampled only in IDLE)
//   k_i          target popcount
//   busy_o       high while enumerating
//   pat_valid_o  pat_data_o holds a valid pattern
//   pat_ready_i  consumer accepts the current pattern
//   pat_data_o   current pattern (popcount == k)
//   pat_idx_o    zero-based ordinal of the current pattern
//   done_o       one-cycle pulse after the final pattern is accepted
//   err_o        one-cycle pulse when start_i arrives with k_i > WIDTH
module popcount23_pattern_gen #(
  parameter int WIDTH = 23,
  parameter int CW    = 5,
  parameter int IDX_W = 21
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic [CW-1:0]    k_i,
  output logic             busy_o,
  output logic             pat_valid_o,
  input  logic             pat_ready_i,
  output logic [WIDTH-1:0] pat_data_o,
  output logic [IDX_W-1:0] pat_idx_o,
  output logic             done_o,
  output logic             err_o
);

  // Shift amount tz+2 reaches at most WIDTH+1.
  localparam int SW = $clog2(WIDTH + 2);

  typedef enum logic {IDLE, RUN} state_e;

  state_e           state_q;
  logic [CW-1:0]    k_q;
  logic [WIDTH-1:0] pat_data_q;
  logic [IDX_W-1:0] pat_idx_q;
  logic             done_q;
  logic             err_q;

  // (1 << n) - 1, built one bit wider so n == WIDTH yields all ones.
  function automatic logic [WIDTH-1:0] low_ones(input logic [CW-1:0] n);
    logic [WIDTH:0] t;
    t = ({{WIDTH{1'b0}}, 1'b1} << n) - {{WIDTH{1'b0}}, 1'b1};
    return t[WIDTH-1:0];
  endfunction

  logic [WIDTH:0]   x, c, r, nxt_w;
  logic [SW-1:0]    tz;
  logic [WIDTH-1:0] last_pat;
  logic [WIDTH-1:0] pat_data_d;
  logic             is_last;

  always_comb begin
    x  = {1'b0, pat_data_q};
    c  = x & (-x);
    r  = x + c;
    // Priority encoder: index of the lowest set bit.
    tz = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (x[i]) tz = SW'(i);
    end
    nxt_w      = r | ((r ^ x) >> (tz + SW'(2)));
    pat_data_d = nxt_w[WIDTH-1:0];
    // Final word has all k ones packed at the top. This also catches k==0,
    // so the Gosper path never sees x==0 and never overflows.
    last_pat   = low_ones(k_q) << (CW'(WIDTH) - k_q);
    is_last    = (pat_data_q == last_pat);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      k_q        <= '0;
      pat_data_q <= '0;
      pat_idx_q  <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            if (k_i > CW'(WIDTH)) begin
              err_q <= 1'b1;
            end else begin
              state_q    <= RUN;
              k_q        <= k_i;
              pat_data_q <= low_ones(k_i);
              pat_idx_q  <= '0;
            end
          end
        end
        RUN: begin
          // start_i is deliberately ignored here; k_q stays latched.
          if (pat_ready_i) begin
            if (is_last) begin
              state_q <= IDLE;
              done_q  <= 1'b1;
            end else begin
              pat_data_q <= pat_data_d;
              pat_idx_q  <= pat_idx_q + IDX_W'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o      = (state_q == RUN);
  assign pat_valid_o = (state_q == RUN);
  assign pat_data_o  = pat_data_q;
  assign pat_idx_o   = pat_idx_q;
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_popcount23_pattern_gen.sv
module tb_popcount23_pattern_gen;
  localparam int WIDTH = 23;
  localparam int CW    = 5;
  localparam int IDX_W = 21;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [CW-1:0]    k = '0;
  logic             pat_ready = 1'b0;
  logic             busy, pat_valid, done, err;
  logic [WIDTH-1:0] pat_data;
  logic [IDX_W-1:0] pat_idx;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  popcount23_pattern_gen #(.WIDTH(WIDTH), .CW(CW), .IDX_W(IDX_W)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .k_i(k),
    .busy_o(busy), .pat_valid_o(pat_valid), .pat_ready_i(pat_ready),
    .pat_data_o(pat_data), .pat_idx_o(pat_idx), .done_o(done), .err_o(err)
  );

  // Reference: smallest word above x with exactly kk ones; 0 if none exists.
  function automatic bit model_next(input int kk, input int x, output int nx);
    nx = 0;
    if (kk == 0) return 1'b0;
    for (int v = x + 1; v < (1 << WIDTH); v++) begin
      if ($countones(v) == kk) begin
        nx = v;
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  task automatic do_start(input int kk);
    @(negedge clk);
    start = 1'b1;
    k = CW'(kk);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, pat_valid, done, err} !== 4'b0 || pat_data !== '0 || pat_idx !== '0) begin
      errors++;
      $display("FAIL reset_outs: got b%b v%b d%b e%b data=%h idx=%0d want all 0",
               busy, pat_valid, done, err, pat_data, pat_idx);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, pat_valid, done, err} !== 4'b0) begin
      errors++;
      $display("FAIL reset_idle: got b%b v%b d%b e%b want 0000", busy, pat_valid, done, err);
    end
  endtask

  task automatic test_k0();
    pat_ready = 1'b1;
    do_start(0);
    checks++;
    if (pat_valid !== 1'b1 || busy !== 1'b1 || pat_data !== 23'h0 || pat_idx !== '0) begin
      errors++;
      $display("FAIL k0_first: got v%b b%b data=%h idx=%0d want v1 b1 data=000000 idx=0",
               pat_valid, busy, pat_data, pat_idx);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || pat_valid !== 1'b0) begin
      errors++;
      $display("FAIL k0_done: got done=%b busy=%b v=%b want 1 0 0", done, busy, pat_valid);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL k0_done_pulse: got done=%b want 0", done);
    end
  endtask

  task automatic test_k1();
    int exp, nx, n;
    bit fin;
    pat_ready = 1'b1;
    do_start(1);
    exp = 1; n = 0; fin = 1'b0;
    for (int cyc = 0; cyc < 60 && !fin; cyc++) begin
      checks++;
      if (pat_valid !== 1'b1 || pat_data !== 23'(exp) || pat_idx !== IDX_W'(n)) begin
        errors++;
        $display("FAIL k1_pat: got v%b data=%h idx=%0d want v1 data=%h idx=%0d",
                 pat_valid, pat_data, pat_idx, exp, n);
      end
      @(negedge clk);
      if (!model_next(1, exp, nx)) fin = 1'b1;
      else begin exp = nx; n++; end
    end
    checks++;
    if (!fin || n != 22 || exp != 32'h400000) begin
      errors++;
      $display("FAIL k1_count: got fin=%b last_idx=%0d last=%h want 1 22 400000", fin, n, exp);
    end
    checks++;
    if (done !== 1'b1 || pat_valid !== 1'b0 || pat_data !== 23'h400000 || pat_idx !== IDX_W'(22)) begin
      errors++;
      $display("FAIL k1_done: got done=%b v=%b data=%h idx=%0d want 1 0 400000 22",
               done, pat_valid, pat_data, pat_idx);
    end
  endtask

  task automatic test_k2();
    int exp, nx, n, prev;
    bit fin;
    int first4 [4] = '{3, 5, 6, 9};
    pat_ready = 1'b1;
    do_start(2);
    exp = 3; n = 0; fin = 1'b0; prev = -1;
    for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
      checks++;
      if (pat_valid !== 1'b1 || pat_data !== 23'(exp) || pat_idx !== IDX_W'(n)) begin
        errors++;
        $display("FAIL k2_pat: got v%b data=%h idx=%0d want v1 data=%h idx=%0d",
                 pat_valid, pat_data, pat_idx, exp, n);
      end
      if (n < 4) begin
        checks++;
        if (pat_data !== 23'(first4[n])) begin
          errors++;
          $display("FAIL k2_first4: got %h want %h at idx %0d", pat_data, first4[n], n);
        end
      end
      checks++;
      if ($countones(pat_data) != 2 || int'(pat_data) <= prev) begin
        errors++;
        $display("FAIL k2_order: got data=%h ones=%0d prev=%h want 2 ones and increasing",
                 pat_data, $countones(pat_data), prev);
      end
      prev = int'(pat_data);
      @(negedge clk);
      if (!model_next(2, exp, nx)) fin = 1'b1;
      else begin exp = nx; n++; end
    end
    checks++;
    if (!fin || done !== 1'b1 || pat_data !== 23'h600000 || pat_idx !== IDX_W'(252)) begin
      errors++;
      $display("FAIL k2_last: got fin=%b done=%b data=%h idx=%0d want 1 1 600000 252",
               fin, done, pat_data, pat_idx);
    end
  endtask

  task automatic test_k23_and_restart();
    pat_ready = 1'b1;
    do_start(23);
    checks++;
    if (pat_valid !== 1'b1 || pat_data !== 23'h7FFFFF || pat_idx !== '0) begin
      errors++;
      $display("FAIL k23_pat: got v%b data=%h idx=%0d want v1 7fffff 0", pat_valid, pat_data, pat_idx);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL k23_done: got done=%b busy=%b want 1 0", done, busy);
    end
    // New request in the same cycle done is visible.
    start = 1'b1;
    k = CW'(0);
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (pat_valid !== 1'b1 || busy !== 1'b1 || pat_data !== 23'h0 || pat_idx !== '0) begin
      errors++;
      $display("FAIL restart_on_done: got v%b b%b data=%h idx=%0d want v1 b1 000000 0",
               pat_valid, busy, pat_data, pat_idx);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL restart_done: got done=%b want 1", done);
    end
  endtask

  task automatic test_err();
    int bad [2] = '{24, 31};
    foreach (bad[i]) begin
      do_start(bad[i]);
      checks++;
      if (err !== 1'b1 || pat_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL err_pulse k=%0d: got err=%b v=%b busy=%b want 1 0 0", bad[i], err, pat_valid, busy);
      end
      @(negedge clk);
      checks++;
      if (err !== 1'b0 || pat_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL err_clear k=%0d: got err=%b v=%b busy=%b want 0 0 0", bad[i], err, pat_valid, busy);
      end
    end
  endtask

  task automatic test_k3_backpressure();
    int exp, nx, n, hs_cnt;
    bit fin, hs;
    pat_ready = 1'b0;
    do_start(3);
    exp = 7; n = 0; hs_cnt = 0; fin = 1'b0;
    for (int cyc = 0; cyc < 20000 && !fin; cyc++) begin
      checks++;
      if (pat_valid !== 1'b1 || pat_data !== 23'(exp) || pat_idx !== IDX_W'(n)) begin
        errors++;
        $display("FAIL k3_pat: got v%b data=%h idx=%0d want v1 data=%h idx=%0d",
                 pat_valid, pat_data, pat_idx, exp, n);
      end
      pat_ready = ($urandom_range(0, 2) != 0);
      start = (n == 900);
      k = CW'(7);
      hs = pat_ready;
      @(negedge clk);
      start = 1'b0;
      if (hs) begin
        hs_cnt++;
        if (!model_next(3, exp, nx)) fin = 1'b1;
        else begin exp = nx; n++; end
      end
    end
    checks++;
    if (!fin || hs_cnt != 1771 || exp != 32'h700000) begin
      errors++;
      $display("FAIL k3_total: got fin=%b handshakes=%0d last=%h want 1 1771 700000", fin, hs_cnt, exp);
    end
    checks++;
    if (done !== 1'b1 || pat_data !== 23'h700000 || pat_idx !== IDX_W'(1770)) begin
      errors++;
      $display("FAIL k3_done: got done=%b data=%h idx=%0d want 1 700000 1770", done, pat_data, pat_idx);
    end
    pat_ready = 1'b1;
  endtask

  task automatic test_k11_reset();
    int exp, nx, n;
    pat_ready = 1'b1;
    do_start(11);
    exp = (1 << 11) - 1; n = 0;
    for (int cyc = 0; cyc < 1100 && n < 1000; cyc++) begin
      checks++;
      if (pat_valid !== 1'b1 || pat_data !== 23'(exp) || pat_idx !== IDX_W'(n)) begin
        errors++;
        $display("FAIL k11_pat: got v%b data=%h idx=%0d want v1 data=%h idx=%0d",
                 pat_valid, pat_data, pat_idx, exp, n);
      end
      @(negedge clk);
      if (model_next(11, exp, nx)) exp = nx;
      n++;
    end
    checks++;
    if (pat_idx !== IDX_W'(1000) || pat_data !== 23'(exp)) begin
      errors++;
      $display("FAIL k11_idx1000: got data=%h idx=%0d want %h 1000", pat_data, pat_idx, exp);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, pat_valid, done, err} !== 4'b0 || pat_data !== '0 || pat_idx !== '0) begin
      errors++;
      $display("FAIL async_reset: got b%b v%b d%b e%b data=%h idx=%0d want all 0",
               busy, pat_valid, done, err, pat_data, pat_idx);
    end
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || pat_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_no_done: got done=%b v=%b want 0 0", done, pat_valid);
      end
    end
    rst_n = 1'b1;
    do_start(5);
    checks++;
    if (pat_valid !== 1'b1 || pat_data !== 23'h00001F || pat_idx !== '0) begin
      errors++;
      $display("FAIL k5_after_reset: got v%b data=%h idx=%0d want v1 00001f 0", pat_valid, pat_data, pat_idx);
    end
  endtask

  initial begin
    test_reset();
    test_k0();
    test_k1();
    test_k2();
    test_k23_and_restart();
    test_err();
    test_k3_backpressure();
    test_k11_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/popcount23_pattern_gen.md
Name: popcount23_pattern_gen

Overview:
- Sequential inverse of the 23-input popcount: given a target count k, emits every 23-bit vector whose exact popcount equals k, one per handshake, in ascending numeric order.
- Used in the characterization harness to drive exact and approximate popcount23 cores class-by-class, so error metrics (MAE/WCE/EP) can be binned per true count.
- Single clock domain; streaming valid/ready output.

Parameters:
- WIDTH, 23, vector width; equals the popcount input width.
- CW, 5, width of k; must hold WIDTH.
- IDX_W, 21, pattern index width; must hold C(WIDTH, WIDTH/2)-1 (1,352,077 for 23).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin enumeration for k. Sampled only in IDLE.
- k  in  CW  target popcount. Sampled with start.
- busy  out  1  high while in RUN.
- pat_valid  out  1  pat_data holds a valid pattern.
- pat_ready  in  1  consumer accepts pattern.
- pat_data  out  WIDTH  current pattern; popcount(pat_data)==k while pat_valid.
- pat_idx  out  IDX_W  zero-based ordinal of the current pattern within the enumeration for k.
- done  out  1  one-cycle pulse after the final pattern is accepted.
- err  out  1  one-cycle pulse when start arrives with k>WIDTH.

Behaviour:
- Reset (async assert, sync release): state=IDLE; all outputs 0 (busy, pat_valid, pat_data, pat_idx, done, err). Reset mid-RUN aborts immediately; no done is produced.
- States: IDLE, RUN.
- IDLE, start=1, k<=WIDTH:
  - Next cycle: state=RUN, busy=1, pat_valid=1, pat_data=(1<<k)-1, pat_idx=0.
  - Start-to-first-valid latency is 1 cycle.
- IDLE, start=1, k>WIDTH: err=1 for the next cycle only; remain IDLE.
- start during RUN: ignored; the latched k is unchanged.
- RUN, handshake (pat_valid & pat_ready):
  - If pat_data is the last pattern, i.e. ((1<<k)-1)<<(WIDTH-k), go to IDLE next cycle: pat_valid=0, busy=0, done=1 for one cycle. pat_data and pat_idx keep their last values.
  - Otherwise advance next cycle: pat_data=next(pat_data), pat_idx+=1.
- Next-pattern rule (Gosper), computed in one cycle on WIDTH+1 bits from x=pat_data:
  - c = x & -x
  - r = x + c
  - next = r | ((r ^ x) >> (tz(x)+2)), where tz(x) is the trailing-zero count of x (priority encoder).
  - Result is truncated to WIDTH bits. The last-pattern check prevents overflow, so next is never evaluated past the end.
- k=0: exactly one pattern, 0x000000. Its handshake produces done; the Gosper path is never used.
- k=WIDTH: exactly one pattern, 0x7FFFFF.
- Backpressure: while pat_valid & !pat_ready, pat_data and pat_idx are held stable and pat_valid stays high. pat_valid never drops without a handshake, except on reset.
- Back-to-back: with pat_ready held high, one pattern is accepted per cycle. Total RUN cycles = C(WIDTH,k).
- A new start is accepted in the same cycle done is high, since the block is already in IDLE.
- Patterns are emitted strictly increasing. No duplicates; none are skipped.

Test Plan:
- k=0, pat_ready=1 -> one pattern 0x000000, pat_idx=0; done 1 cycle after the handshake; busy high for exactly 1 cycle.
- k=1, pat_ready=1 -> 23 patterns 0x000001, 0x000002, ..., 0x400000; last pat_idx=22; then done.
- k=2 -> first four patterns 0x000003, 0x000005, 0x000006, 0x000009; last 0x600000 at pat_idx=252; every emitted word has popcount 2 and is strictly increasing.
- k=23 -> single pattern 0x7FFFFF, then done. k=24 -> err pulse for 1 cycle, pat_valid stays 0, busy stays 0.
- k=3 with pat_ready randomly deasserted -> pat_data/pat_idx are stable during stalls; exactly 1771 handshakes; last pattern 0x700000; a start asserted mid-run has no effect.
- k=11, rst_n pulsed low at pat_idx=1000 -> all outputs 0 asynchronously, no done; after release, start with k=5 -> first pattern 0x00001F at pat_idx=0.
